imm_gen_pipe: RTL and testbench



---
 rtl/imm_gen_pkg.sv | 23 ++
 rtl/imm_decode_comb.sv | 71 +++++++
 rtl/imm_gen_pipe.sv | 142 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the immediate generator.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_SH   = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational RV32I/RV64I immediate decode: instruction word to
// sign-extended immediate, format code and no-immediate flag.
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [5:0] shamt;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];

  // RV64 shifts use a 6-bit shamt; funct7 bits are deliberately excluded
  // so that SRAI reports only the shift amount.
  always_comb begin
    if (XLEN == 64) shamt = inst_i[25:20];
    else            shamt = {1'b0, inst_i[24:20]};
  end

  // Opcode decode; size casts of signed operands perform the sign extension.
  always_comb begin
    imm_o     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        fmt_o = FMT_I;
        imm_o = XLEN'($signed(inst_i[31:20]));
      end
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          fmt_o = FMT_SH;
          imm_o = XLEN'(shamt);
        end else begin
          fmt_o = FMT_I;
          imm_o = XLEN'($signed(inst_i[31:20]));
        end
      end
      OP_STORE: begin
        fmt_o = FMT_S;
        imm_o = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
      end
      OP_BRANCH: begin
        fmt_o = FMT_B;
        imm_o = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25],
                               inst_i[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        fmt_o = FMT_U;
        imm_o = XLEN'($signed({inst_i[31:12], 12'b0}));
      end
      OP_JAL: begin
        fmt_o = FMT_J;
        imm_o = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20],
                               inst_i[30:21], 1'b0}));
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode registered on acceptance, one
// main output register plus a skid register, illegal-opcode counter.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [XLEN-1:0]  dec_imm;
  imm_fmt_e         dec_fmt;
  logic             dec_illegal;

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q, main_imm_d;
  imm_fmt_e         main_fmt_q, main_fmt_d;
  logic             main_ill_q, main_ill_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;

  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  imm_fmt_e         skid_fmt_q, skid_fmt_d;
  logic             skid_ill_q, skid_ill_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_fire;
  logic main_free;

  imm_decode_comb #(.XLEN(XLEN)) u_decode (
    .inst_i    (in_inst),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  // in_ready comes straight from the skid flop, so out_ready never
  // reaches it combinationally.
  assign in_ready  = !skid_valid_q;
  assign in_fire   = in_valid && in_ready;
  assign main_free = !main_valid_q || out_ready;

  // Gated by reset so no output handshake completes in the reset cycle.
  assign out_valid   = main_valid_q && !reset;
  assign out_imm     = main_imm_q;
  assign out_fmt     = main_fmt_q;
  assign out_illegal = main_ill_q;
  assign out_tag     = main_tag_q;
  assign illegal_cnt = cnt_q;

  // Next-state for main/skid entries: skid drains first to keep order.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_fmt_d   = main_fmt_q;
    main_ill_d   = main_ill_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_ill_d   = skid_ill_q;
    skid_tag_d   = skid_tag_q;
    if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_fmt_d   = skid_fmt_q;
        main_ill_d   = skid_ill_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_imm_d   = dec_imm;
        main_fmt_d   = dec_fmt;
        main_ill_d   = dec_illegal;
        main_tag_d   = in_tag;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_fmt_d   = dec_fmt;
      skid_ill_d   = dec_illegal;
      skid_tag_d   = in_tag;
    end
  end

  // Saturating count of accepted illegal opcodes.
  always_comb begin
    cnt_d = cnt_q;
    if (in_fire && dec_illegal && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_fmt_q   <= FMT_NONE;
      main_ill_q   <= 1'b0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_NONE;
      skid_ill_q   <= 1'b0;
      skid_tag_q   <= '0;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_fmt_q   <= main_fmt_d;
      main_ill_q   <= main_ill_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_ill_q   <= skid_ill_d;
      skid_tag_q   <= skid_tag_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit/8-bit-counter instance and a
// 64-bit/2-bit-counter instance driven in lockstep, checked against a
// queue-based reference model.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm;
  logic [2:0]  a_out_fmt;
  logic [7:0]  a_out_tag, a_cnt;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;
  logic [7:0]  b_out_tag;
  logic [1:0]  b_cnt;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
    .out_illegal(a_out_illegal), .out_tag(a_out_tag), .illegal_cnt(a_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
    .out_illegal(b_out_illegal), .out_tag(b_out_tag), .illegal_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] i32;
    logic [63:0] i64;
    logic [2:0]  fmt;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          m_cnt8 = 0;
  int          m_cnt2 = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_imm;
  logic [7:0]  prev_tag;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference decode from the format rules, using integer arithmetic.
  function automatic void ref_dec(input logic [31:0] i, output logic [31:0] e32,
                                  output logic [63:0] e64, output logic [2:0] fmt,
                                  output logic ill);
    longint v, v32;
    v = 0; v32 = 0; fmt = FMT_NONE; ill = 1'b0;
    case (i[6:0])
      7'b0000011, 7'b1100111: begin
        fmt = FMT_I; v = longint'(i[31:20]); if (i[31]) v -= 4096;
      end
      7'b0010011: begin
        if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
          fmt = FMT_SH; v = longint'(i[25:20]); v32 = longint'(i[24:20]);
        end else begin
          fmt = FMT_I; v = longint'(i[31:20]); if (i[31]) v -= 4096;
        end
      end
      7'b0100011: begin
        fmt = FMT_S; v = (longint'(i[31:25]) << 5) + longint'(i[11:7]);
        if (i[31]) v -= 4096;
      end
      7'b1100011: begin
        fmt = FMT_B;
        v = (longint'(i[31]) << 12) + (longint'(i[7]) << 11) +
            (longint'(i[30:25]) << 5) + (longint'(i[11:8]) << 1);
        if (i[31]) v -= (longint'(1) << 13);
      end
      7'b0110111, 7'b0010111: begin
        fmt = FMT_U; v = longint'(i[31:12]) << 12;
        if (i[31]) v -= (longint'(1) << 32);
      end
      7'b1101111: begin
        fmt = FMT_J;
        v = (longint'(i[31]) << 20) + (longint'(i[19:12]) << 12) +
            (longint'(i[20]) << 11) + (longint'(i[30:21]) << 1);
        if (i[31]) v -= (longint'(1) << 21);
      end
      default: ill = 1'b1;
    endcase
    if (fmt != FMT_SH) v32 = v;
    e64 = v;
    e32 = v32[31:0];
  endfunction

  // One clock: drive after the falling edge, then check and model the
  // transfers that the next rising edge will perform.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic [7:0] tag,
                       input logic rdy, output logic acc);
    exp_t e;
    logic [31:0] e32;
    logic [63:0] e64;
    logic [2:0]  f;
    logic        il;
    @(negedge clk);
    in_valid = v; in_inst = inst; in_tag = tag; out_ready = rdy;
    #1;
    chk("in_ready_64", b_in_ready, a_in_ready);
    chk("out_valid_64", b_out_valid, a_out_valid);
    chk("cnt8", a_cnt, m_cnt8);
    chk("cnt2", b_cnt, m_cnt2);
    if (prev_stall) begin
      chk("hold_valid", a_out_valid, 1);
      chk("hold_imm", a_out_imm, prev_imm);
      chk("hold_tag", a_out_tag, prev_tag);
    end
    prev_stall = a_out_valid && !out_ready;
    prev_imm = a_out_imm;
    prev_tag = a_out_tag;
    if (a_out_valid && out_ready) begin
      chk("out_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("imm32", a_out_imm, e.i32);
        chk("imm64", b_out_imm, e.i64);
        chk("fmt", a_out_fmt, e.fmt);
        chk("fmt64", b_out_fmt, e.fmt);
        chk("illegal", a_out_illegal, e.ill);
        chk("tag", a_out_tag, e.tag);
        chk("tag64", b_out_tag, e.tag);
      end
    end
    acc = in_valid && a_in_ready;
    if (acc) begin
      ref_dec(in_inst, e32, e64, f, il);
      e.i32 = e32; e.i64 = e64; e.fmt = f; e.ill = il; e.tag = in_tag;
      exp_q.push_back(e);
      if (il) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_q.delete();
    m_cnt8 = 0; m_cnt2 = 0; prev_stall = 1'b0;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_cnt64", b_cnt, 0);
    chk("rst_imm", a_out_imm, 0);
    chk("rst_fmt", a_out_fmt, FMT_NONE);
    chk("rst_illegal", a_out_illegal, 0);
    chk("rst_tag", a_out_tag, 0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  ops [10];
    ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0000000};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 9)];
    if (w[6:0] == 7'b0000000) w[6:0] = 7'($urandom);
    return w;
  endfunction

  logic [31:0] dir_vec [9];
  logic        acc;
  int          t;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b0;
    dir_vec = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'h00509093,
                32'h4030D093, 32'h0000007F, 32'h00000033, 32'h00112623,
                32'h008000EF};
    do_reset();

    for (int k = 0; k < 9; k++) cycle(1'b1, dir_vec[k], 8'(k + 16), 1'b1, acc);
    repeat (3) cycle(1'b0, 32'h0, 8'h0, 1'b1, acc);
    chk("cnt_two_illegal", a_cnt, 2);
    chk("queue_empty_directed", exp_q.size(), 0);

    cycle(1'b1, 32'hFFF00093, 8'd1, 1'b0, acc);
    chk("bp_acc1", acc, 1);
    cycle(1'b1, 32'h00509093, 8'd2, 1'b0, acc);
    chk("bp_acc2", acc, 1);
    cycle(1'b1, 32'h123450B7, 8'd3, 1'b0, acc);
    chk("bp_in_ready_low", a_in_ready, 0);
    chk("bp_head_tag", a_out_tag, 1);
    t = 3;
    for (int k = 0; k < 20 && t <= 4; k++) begin
      cycle(1'b1, (t == 3) ? 32'h123450B7 : 32'hFE000EE3, 8'(t), 1'b1, acc);
      if (acc) t++;
    end
    chk("bp_all_sent", t, 5);
    repeat (4) cycle(1'b0, 32'h0, 8'h0, 1'b1, acc);
    chk("bp_queue_empty", exp_q.size(), 0);

    cycle(1'b1, 32'h0000007F, 8'd5, 1'b0, acc);
    cycle(1'b1, 32'h0000007F, 8'd6, 1'b0, acc);
    cycle(1'b0, 32'h0, 8'h0, 1'b0, acc);
    chk("full_in_ready", a_in_ready, 0);
    do_reset();
    repeat (4) cycle(1'b0, 32'h0, 8'h0, 1'b1, acc);

    for (int k = 0; k < 800; k++) begin
      cycle($urandom_range(0, 3) != 0, rand_inst(), 8'($urandom),
            $urandom_range(0, 3) != 0, acc);
    end
    for (int k = 0; k < 10; k++) cycle(1'b0, 32'h0, 8'h0, 1'b1, acc);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("cnt2_saturated", b_cnt, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
